// File: rtl/resta_pf_if.sv
// Operand/result handshake bundle for the single-precision subtractor.
// The master side supplies operands and takes results; the slave side is the
// arithmetic block.
interface resta_pf_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [2:0]  flags;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/resta_pf.sv
// Multi-cycle IEEE-754 single-precision subtractor (a - b, computed as a + (-b)).
// One operation in flight: IDLE captures, ALIGN orders and aligns, ADD forms the
// 25-bit magnitude, NORM shifts one bit per cycle, DONE holds the result until
// the consumer takes it. Rounding is truncation; flags are {invalid, overflow,
// underflow}.
module resta_pf (
  input  logic       clk,
  input  logic       rst_n,
  resta_pf_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  state_t      state;

  // Captured operands (b already negated), hidden bit applied.
  logic        signA;
  logic        signB;
  logic [7:0]  expA;
  logic [7:0]  expB;
  logic [23:0] mantA;
  logic [23:0] mantB;
  logic        effSub;

  // Working datapath after alignment.
  logic [24:0] workMant;
  logic [23:0] mantSmall;
  logic [8:0]  workExp;
  logic        resSign;

  // Combinational alignment and add results consumed by the FSM.
  logic        aBigger;
  logic [7:0]  expBig;
  logic [7:0]  expSmall;
  logic [7:0]  shiftAmt;
  logic [23:0] mantBigC;
  logic [23:0] mantSmallC;
  logic [23:0] alignedSmall;
  logic        signBig;
  logic [24:0] sumMant;

  // Order operands by magnitude, align the smaller one, and form the sum.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    aBigger    = {expA, mantA} >= {expB, mantB};
    expBig     = expA;
    expSmall   = expB;
    mantBigC   = mantA;
    mantSmallC = mantB;
    signBig    = signA;
    if (!aBigger) begin
      expBig     = expB;
      expSmall   = expA;
      mantBigC   = mantB;
      mantSmallC = mantA;
      signBig    = signB;
    end
    shiftAmt     = expBig - expSmall;
    alignedSmall = (shiftAmt >= 8'd24) ? 24'd0 : (mantSmallC >> shiftAmt);
    sumMant      = effSub ? (workMant - {1'b0, mantSmall})
                          : (workMant + {1'b0, mantSmall});
  end

  // Control FSM with registered handshake outputs, result and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the datapath registers are reset too, so nothing captured before
      // an abort can leak into a later result.
      state         <= IDLE;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.result    <= 32'd0;
      bus.flags     <= 3'b000;
      signA         <= 1'b0;
      signB         <= 1'b0;
      expA          <= 8'd0;
      expB          <= 8'd0;
      mantA         <= 24'd0;
      mantB         <= 24'd0;
      effSub        <= 1'b0;
      workMant      <= 25'd0;
      mantSmall     <= 24'd0;
      workExp       <= 9'd0;
      resSign       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here, so every register sees the
      // pre-edge values of the others regardless of statement order.
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            signA        <= bus.a[31];
            signB        <= ~bus.b[31];
            expA         <= bus.a[30:23];
            expB         <= bus.b[30:23];
            mantA        <= (bus.a[30:23] == 8'd0) ? 24'd0 : {1'b1, bus.a[22:0]};
            mantB        <= (bus.b[30:23] == 8'd0) ? 24'd0 : {1'b1, bus.b[22:0]};
            effSub       <= bus.a[31] ^ ~bus.b[31];
            bus.in_ready <= 1'b0;
            if (bus.a[30:23] == 8'hFF || bus.b[30:23] == 8'hFF) begin
              state         <= DONE;
              bus.out_valid <= 1'b1;
              bus.result    <= QNAN;
              bus.flags     <= 3'b100;
            end else begin
              state <= ALIGN;
            end
          end
        end

        ALIGN: begin
          workMant  <= {1'b0, mantBigC};
          mantSmall <= alignedSmall;
          workExp   <= {1'b0, expBig};
          resSign   <= signBig;
          state     <= ADD;
        end

        ADD: begin
          if (sumMant == 25'd0) begin
            state         <= DONE;
            bus.out_valid <= 1'b1;
            bus.result    <= 32'd0;
            bus.flags     <= 3'b000;
          end else begin
            workMant <= sumMant;
            state    <= NORM;
          end
        end

        NORM: begin
          if (workExp == 9'd255) begin
            // A carry pushed the exponent to the top: signed infinity.
            state         <= DONE;
            bus.out_valid <= 1'b1;
            bus.result    <= {resSign, 8'hFF, 23'd0};
            bus.flags     <= 3'b010;
          end else if (workMant[24]) begin
            workMant <= workMant >> 1;
            workExp  <= workExp + 9'd1;
          end else if (!workMant[23]) begin
            if (workExp <= 9'd1) begin
              // Another left shift would leave the normal range: flush to zero.
              state         <= DONE;
              bus.out_valid <= 1'b1;
              bus.result    <= 32'd0;
              bus.flags     <= 3'b001;
            end else begin
              workMant <= workMant << 1;
              workExp  <= workExp - 9'd1;
            end
          end else begin
            state         <= DONE;
            bus.out_valid <= 1'b1;
            bus.result    <= {resSign, workExp[7:0], workMant[22:0]};
            bus.flags     <= 3'b000;
          end
        end

        DONE: begin
          if (bus.out_ready) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
          end
        end

        default: begin
          state         <= IDLE;
          bus.in_ready  <= 1'b1;
          bus.out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_resta_pf.sv
// Scoreboard bench for resta_pf: the driver pushes the expected result, flags
// and latency for every accepted operand pair; an independent monitor pops and
// compares whenever out_valid is presented.
module tb_resta_pf;

  localparam int PERIOD = 10;

  typedef struct {
    logic [31:0] res;
    logic [2:0]  flg;
    int          lat;
    longint      t0;
    string       name;
  } exp_t;

  logic clk;
  logic rst_n;

  resta_pf_if bus ();

  resta_pf dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  exp_t sbq[$];
  int   nVec        = 0;
  int   nFail       = 0;
  int   stallCycles = 0;
  bit   holding     = 1'b0;

  initial clk = 1'b0;
  always #(PERIOD / 2) clk = ~clk;

  function automatic void check(string name, logic [63:0] act, logic [63:0] req);
    nVec++;
    if (act !== req) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endfunction

  function automatic exp_t mk(logic [31:0] res, logic [2:0] flg, int lat, string name);
    exp_t e;
    e.res  = res;
    e.flg  = flg;
    e.lat  = lat;
    e.t0   = 0;
    e.name = name;
    return e;
  endfunction

  // Reference: value-level description of a + (-b) with truncating alignment,
  // normalisation by leading-one position, and range limits.
  function automatic exp_t refModel(logic [31:0] x, logic [31:0] y);
    int     ex, ey, eb, es, d, pos, e, shifts;
    longint mx, my, mb, ms, sm, v, m;
    bit     sx, sy, s;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    sx = x[31];
    sy = ~y[31];
    if (ex == 255 || ey == 255) return mk(32'h7FC00000, 3'b100, 1, "rnd");
    mx = (ex == 0) ? 0 : (longint'(x[22:0]) + (64'd1 << 23));
    my = (ey == 0) ? 0 : (longint'(y[22:0]) + (64'd1 << 23));
    if (ex > ey || (ex == ey && mx >= my)) begin
      eb = ex; es = ey; mb = mx; ms = my; s = sx;
    end else begin
      eb = ey; es = ex; mb = my; ms = mx; s = sy;
    end
    d  = eb - es;
    sm = (d >= 24) ? 0 : (ms >> d);
    v  = (sx == sy) ? (mb + sm) : (mb - sm);
    if (v == 0) return mk(32'h0, 3'b000, 3, "rnd");
    pos = 24;
    while (((v >> pos) & 1) == 0) pos--;
    e      = eb + pos - 23;
    shifts = (pos >= 23) ? (pos - 23) : (23 - pos);
    if (e >= 255) return mk({s, 8'hFF, 23'd0}, 3'b010, 4 + shifts, "rnd");
    if (e < 1) return mk(32'h0, 3'b001, 4 + (eb - 1), "rnd");
    m = (pos >= 23) ? (v >> (pos - 23)) : (v << (23 - pos));
    return mk({s, e[7:0], m[22:0]}, 3'b000, 4 + shifts, "rnd");
  endfunction

  // Wait for in_ready (pulsing ignored garbage meanwhile), then present one pair.
  task automatic issue(input logic [31:0] x, input logic [31:0] y,
                       input bit doPush, input exp_t e);
    int waitCnt;
    waitCnt = 0;
    @(negedge clk);
    while (!bus.in_ready && waitCnt < 400) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.a        = $urandom;
      bus.b        = $urandom;
      @(negedge clk);
      waitCnt++;
    end
    if (!bus.in_ready) begin
      check("in_ready timeout", {63'd0, bus.in_ready}, 64'd1);
      bus.in_valid = 1'b0;
      return;
    end
    bus.a        = x;
    bus.b        = y;
    bus.in_valid = 1'b1;
    if (doPush) begin
      e.t0 = longint'($time);
      sbq.push_back(e);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    check({e.name, " accepted"}, {63'd0, bus.in_ready}, 64'd0);
  endtask

  // Monitor: compare each presented result, check it stays stable while held.
  initial begin : monitor
    exp_t        e;
    logic [31:0] hr;
    logic [2:0]  hf;
    bus.out_ready = 1'b0;
    hr = '0;
    hf = '0;
    forever begin
      @(negedge clk);
      if (bus.out_valid) begin
        check("in_ready low in DONE", {63'd0, bus.in_ready}, 64'd0);
        if (!holding) begin
          if (sbq.size() == 0) begin
            check("spurious out_valid", {63'd0, bus.out_valid}, 64'd0);
          end else begin
            e = sbq.pop_front();
            check({e.name, " result"}, {32'd0, bus.result}, {32'd0, e.res});
            check({e.name, " flags"}, {61'd0, bus.flags}, {61'd0, e.flg});
            check({e.name, " latency"}, 64'(($time - e.t0) / PERIOD), 64'(e.lat));
          end
          holding = 1'b1;
          hr = bus.result;
          hf = bus.flags;
        end else begin
          check("held result", {32'd0, bus.result}, {32'd0, hr});
          check("held flags", {61'd0, bus.flags}, {61'd0, hf});
        end
        if (stallCycles > 0) begin
          bus.out_ready = 1'b0;
          stallCycles--;
        end else begin
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        if (bus.out_ready) holding = 1'b0;
      end else begin
        bus.out_ready = 1'($urandom_range(0, 1));
        holding = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    exp_t        none;
    exp_t        e;
    logic [31:0] x, y;
    logic [7:0]  ex;
    none = mk(32'h0, 3'b000, 0, "reset-abort");
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.a        = 32'd0;
    bus.b        = 32'd0;
    repeat (2) @(negedge clk);
    check("reset in_ready", {63'd0, bus.in_ready}, 64'd1);
    check("reset out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("reset result", {32'd0, bus.result}, 64'd0);
    check("reset flags", {61'd0, bus.flags}, 64'd0);
    rst_n = 1'b1;

    // Directed cases with hand-derived results and latencies.
    issue(32'h40400000, 32'h3F800000, 1'b1, mk(32'h40000000, 3'b000, 4, "3-1"));
    issue(32'h3F800000, 32'h3F400000, 1'b1, mk(32'h3E800000, 3'b000, 6, "1-0.75"));
    issue(32'h3F800000, 32'hBF800000, 1'b1, mk(32'h40000000, 3'b000, 5, "1+1"));
    issue(32'h3F800000, 32'h3F800000, 1'b1, mk(32'h00000000, 3'b000, 3, "1-1"));
    issue(32'h7F800000, 32'h3F800000, 1'b1, mk(32'h7FC00000, 3'b100, 1, "inf-1"));
    issue(32'h7F7FFFFF, 32'hFF7FFFFF, 1'b1, mk(32'h7F800000, 3'b010, 5, "overflow"));
    issue(32'h00800000, 32'h00C00000, 1'b1, mk(32'h00000000, 3'b001, 4, "underflow"));

    // Consumer stalls for 10 cycles while garbage in_valid pulses arrive.
    issue(32'h40400000, 32'h3F800000, 1'b1, mk(32'h40000000, 3'b000, 4, "stall"));
    stallCycles = 10;

    // Abort during NORM of 1.0-0.75: accept edge, ALIGN, ADD, then NORM.
    issue(32'h3F800000, 32'h3F400000, 1'b0, none);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort in_ready", {63'd0, bus.in_ready}, 64'd1);
    check("abort out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("abort result", {32'd0, bus.result}, 64'd0);
    check("abort flags", {61'd0, bus.flags}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    issue(32'h40400000, 32'h3F800000, 1'b1, mk(32'h40000000, 3'b000, 4, "after-abort"));

    // Randomised operands biased toward cancellation, specials and range limits.
    for (int i = 0; i < 250; i++) begin
      x = $urandom;
      y = $urandom;
      ex = x[30:23];
      case ($urandom_range(0, 9))
        0: y[30:23] = 8'hFF;
        1: x[30:23] = 8'h00;
        2, 3, 4: begin
          y[30:23] = ex;
          y[22:0]  = x[22:0] ^ 23'($urandom_range(0, 255));
          y[31]    = x[31];
        end
        5: begin
          x[30:23] = 8'd254;
          y[30:23] = 8'(254 - $urandom_range(0, 2));
          y[31]    = ~x[31];
        end
        6: begin
          x[30:23] = 8'($urandom_range(1, 3));
          y[30:23] = x[30:23];
          y[31]    = x[31];
        end
        default: y[30:23] = ex + 8'($urandom_range(0, 30)) - 8'd15;
      endcase
      e = refModel(x, y);
      issue(x, y, 1'b1, e);
    end

    for (int i = 0; i < 500 && (sbq.size() != 0 || holding); i++) @(negedge clk);
    if (sbq.size() != 0) check("drain pending results", 64'(sbq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule

// File: doc/resta_pf.md
RESTA_PF -- requirements
Module: resta_pf

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port clk, input, 1: rising-edge clock for all state.
REQ-003 Port rst_n, input, 1: asynchronous active-low reset.
REQ-004 Port in_valid, input, 1: operands a and b are valid.
REQ-005 Port in_ready, output, 1: block accepts operands this cycle.
REQ-006 Port a, input, 32: IEEE-754 single-precision minuend.
REQ-007 Port b, input, 32: IEEE-754 single-precision subtrahend.
REQ-008 Port out_valid, output, 1: result and flags are valid.
REQ-009 Port out_ready, input, 1: consumer takes the result.
REQ-010 Port result, output, 32: a - b in single-precision format.
REQ-011 Port flags, output, 3: {invalid, overflow, underflow} for the current result.

Function
REQ-012 The block SHALL compute a - b as a + (-b), with b's sign bit inverted at capture.
REQ-013 FSM states SHALL be IDLE, ALIGN, ADD, NORM and DONE; in_ready SHALL be 1 only in IDLE.
REQ-014 On in_valid & in_ready, IDLE SHALL capture a and b.
  - If either exponent is 255: go to DONE with result = 0x7FC00000 and invalid = 1.
  - Otherwise: go to ALIGN.
REQ-015 An exponent of 0 SHALL mean an operand of value zero (mantissa 0 in the datapath); for any other exponent the hidden 1 is prepended, giving a 24-bit mantissa.
REQ-016 ALIGN (1 cycle) SHALL:
  - order the operands by magnitude (exponent, then mantissa);
  - shift the smaller mantissa right by the exponent difference and drop the shifted-out bits;
  - force the smaller mantissa to 0 when the difference is 24 or more;
  - take the larger exponent as the working exponent.
REQ-017 ADD (1 cycle) SHALL form a 25-bit sum:
  - equal signs: add the mantissas;
  - different signs: subtract the smaller from the larger;
  - result sign = sign of the larger-magnitude operand.
REQ-018 If the ADD result is zero, the FSM SHALL go to DONE with result = 0x00000000 and all flags 0.
REQ-019 NORM SHALL perform at most one shift per cycle:
  - bit24 set: shift right 1, exponent +1;
  - else bit23 clear: shift left 1, exponent -1;
  - else (normalized): go to DONE.
REQ-020 Rounding SHALL be truncation (round toward zero).
REQ-021 Overflow: if the exponent reaches 255, result SHALL be a signed infinity (exponent 255, mantissa 0) with overflow = 1.
REQ-022 Underflow: if a left shift would take the exponent below 1, result SHALL be 0x00000000 with underflow = 1.
REQ-023 Latency from the accept edge to out_valid SHALL be:
  - special operands: 1 cycle;
  - zero difference: 3 cycles;
  - otherwise: 4 cycles plus 1 per NORM shift.
REQ-024 DONE SHALL hold out_valid = 1 with result and flags stable until out_ready = 1.
  - On out_ready = 1, the FSM returns to IDLE on the next edge.
  - A new operand is accepted no earlier than the cycle after that handshake.
REQ-025 in_valid while not in IDLE SHALL be ignored; operands SHALL NOT be queued.
REQ-026 Datapath widths SHALL be: mantissa 25 bits, working exponent 9 bits (carry and borrow detection), shift amount 8 bits.

Reset
REQ-027 While rst_n = 0, the FSM SHALL be in IDLE, with in_ready = 1, out_valid = 0, result = 0x00000000 and flags = 000.
REQ-028 Asserting rst_n mid-operation SHALL abort the operation immediately, discard the captured operands and produce no out_valid afterwards.
REQ-029 After rst_n deasserts, the block SHALL accept operands on the first rising edge where in_valid = 1.

Verification
REQ-030 a=0x40400000, b=0x3F800000 (3.0-1.0) -> result 0x40000000, flags 000, out_valid 4 cycles after accept.
REQ-031 a=0x3F800000, b=0x3F400000 (1.0-0.75) -> 0x3E800000 after 2 left shifts, out_valid 6 cycles after accept; a=0x3F800000, b=0xBF800000 (1.0-(-1.0)) -> 0x40000000, 5 cycles.
REQ-032 a=b=0x3F800000 -> 0x00000000, flags 000, 3 cycles; a=0x7F800000, b=0x3F800000 -> 0x7FC00000, invalid=1, 1 cycle.
REQ-033 a=0x7F7FFFFF, b=0xFF7FFFFF -> 0x7F800000, overflow=1; a=0x00800000, b=0x00C00000 -> 0x00000000, underflow=1.
REQ-034 out_ready held 0 for 10 cycles in DONE -> out_valid=1 and result/flags unchanged for all 10 cycles, in_ready=0 and in_valid pulses ignored; the next operand is accepted only after the handshake.
REQ-035 rst_n pulsed low during NORM of the 1.0-0.75 case -> outputs at reset values within the same cycle, no out_valid afterwards; the next 3.0-1.0 request completes normally with 0x40000000.
